// File: rtl/ghost_pkg.sv
// ghost_pkg: shared definitions for the ghost motion slice.
//   DIR_*          one-hot heading encoding {down, up, right, left}
//   opposite()     reverse of a one-hot heading (DIR_NONE maps to DIR_NONE)
//   ghost_state_t  integrator state
//   Y_LIMIT        bottom-most legal Y position (vertical range is 0..Y_LIMIT)
package ghost_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b1000;

  localparam int Y_LIMIT = 479;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_FROZEN
  } ghost_state_t;

  // Swap left<->right and up<->down bit pairs.
  function automatic logic [3:0] opposite(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: brings the asynchronous frame strobe into the clk domain
// and turns each rising edge into a single-cycle registered pulse.
//   clk, rst   system clock, async active-high reset
//   frame_clk  asynchronous frame strobe
//   tick       one clk-cycle pulse, 3 cycles after a frame_clk rising edge
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic tick
);

  // [0],[1]: two-flop synchronizer; [2]: previous synchronized level.
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe <= '0;
      tick      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], frame_clk};
      tick      <= sync_pipe[1] & ~sync_pipe[2];
    end
  end

endmodule

// File: rtl/ghost_motion.sv
// ghost_motion: per-ghost position integrator. Consumes the one-hot Movement
// request and wall flags once per frame tick and advances GhostX/GhostY.
//   Clk, Reset                   clock, async active-high reset
//   frame_clk                    asynchronous per-frame strobe
//   Over                         game over; freezes all motion while high
//   Movement                     requested heading {down, up, right, left}
//   up_ok/down_ok/left_ok/right_ok  move legal from the current position
//   GhostX, GhostY               registered position
//   GhostDir                     committed heading (0000 when stopped)
//   Moving                       high while in MOVE
// Build option: GHOST_TUNNEL_EN wraps horizontal motion between X_MIN and
// X_MAX; otherwise leaving the horizontal range stops the ghost.
module ghost_motion
  import ghost_pkg::*;
#(
  parameter int X_START = 320,
  parameter int Y_START = 240,
  parameter int TILE    = 16,
  parameter int STEP    = 2,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 624
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       Over,
  input  logic [3:0] Movement,
  input  logic       up_ok,
  input  logic       down_ok,
  input  logic       left_ok,
  input  logic       right_ok,
  output logic [9:0] GhostX,
  output logic [9:0] GhostY,
  output logic [3:0] GhostDir,
  output logic       Moving
);

  localparam int TB = $clog2(TILE);

  ghost_state_t state;
  logic         tick;
  logic [3:0]   oks;
  logic         req_vld, req_ok, cur_ok, aligned, step_ok;
  logic [3:0]   plan;
  logic [9:0]   nx, ny;
  int           xs, ys;

  frame_tick_sync u_sync (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign oks     = {down_ok, up_ok, right_ok, left_ok};
  assign aligned = (GhostX[TB-1:0] == '0) && (GhostY[TB-1:0] == '0);

  // Heading for this tick (DIR_NONE = stop), then the stepped position and
  // whether that step stays in range.
  always_comb begin
    req_vld = $onehot(Movement);
    req_ok  = req_vld && |(Movement & oks);
    cur_ok  = |(GhostDir & oks);
    plan    = DIR_NONE;
    case (state)
      ST_IDLE: if (req_ok) plan = Movement;
      ST_MOVE: begin
        if (aligned) begin
          if (req_ok)      plan = Movement;
          else if (cur_ok) plan = GhostDir;
        end else begin
          // Mid-tile: only an exact reversal is honoured, walls are ignored.
          if (req_vld && Movement == opposite(GhostDir)) plan = Movement;
          else                                           plan = GhostDir;
        end
      end
      default: plan = DIR_NONE;
    endcase

    xs = int'(GhostX);
    ys = int'(GhostY);
    case (plan)
      DIR_LEFT:  xs = xs - STEP;
      DIR_RIGHT: xs = xs + STEP;
      DIR_UP:    ys = ys - STEP;
      DIR_DOWN:  ys = ys + STEP;
      default:   ;
    endcase

    step_ok = (plan != DIR_NONE);
`ifdef GHOST_TUNNEL_EN
    if (xs < X_MIN)      xs = X_MAX;
    else if (xs > X_MAX) xs = X_MIN;
`else
    if (xs < X_MIN || xs > X_MAX) step_ok = 1'b0;
`endif
    if (ys < 0 || ys > Y_LIMIT) step_ok = 1'b0;
    nx = 10'(xs);
    ny = 10'(ys);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      GhostX   <= 10'(X_START);
      GhostY   <= 10'(Y_START);
      GhostDir <= DIR_NONE;
      Moving   <= 1'b0;
      state    <= ST_IDLE;
    end else if (Over) begin
      // Freeze wins over a coincident tick; position and heading are held.
      state  <= ST_FROZEN;
      Moving <= 1'b0;
    end else if (state == ST_FROZEN) begin
      state    <= ST_IDLE;
      GhostDir <= DIR_NONE;
    end else if (tick) begin
      if (step_ok) begin
        GhostX   <= nx;
        GhostY   <= ny;
        GhostDir <= plan;
        Moving   <= 1'b1;
        state    <= ST_MOVE;
      end else begin
        GhostDir <= DIR_NONE;
        Moving   <= 1'b0;
        state    <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ghost_motion.sv
module tb_ghost_motion;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, Over;
  logic [3:0] Movement;
  logic       up_ok, down_ok, left_ok, right_ok;
  logic [9:0] GhostX, GhostY;
  logic [3:0] GhostDir;
  logic       Moving;

  ghost_motion dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Over(Over),
    .Movement(Movement), .up_ok(up_ok), .down_ok(down_ok),
    .left_ok(left_ok), .right_ok(right_ok),
    .GhostX(GhostX), .GhostY(GhostY), .GhostDir(GhostDir), .Moving(Moving)
  );

  always #5 Clk = ~Clk;

  int ncmp = 0, nfail = 0;

  // Reference model: position in plain integers, heading as a code
  // (0 left, 1 right, 2 up, 3 down, -1 stopped).
  int mx, my, mdir;
  bit mmov, mfrz;
  int dxs[4] = '{-2, 2, 0, 0};
  int dys[4] = '{0, 0, -2, 2};

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int code_of(input logic [3:0] m);
    case (m)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [3:0] onehot_of(input int c);
    if (c < 0) return 4'd0;
    return 4'(1 << c);
  endfunction

  task automatic model_reset();
    mx = 320; my = 240; mdir = -1; mmov = 0; mfrz = 0;
  endtask

  task automatic model_tick(input logic [3:0] mov, input logic [3:0] oks);
    int  req, want, tx, ty;
    bit  algn, stop;
    if (mfrz) return;
    req  = code_of(mov);
    algn = (mx % 16 == 0) && (my % 16 == 0);
    want = -1;
    if (!mmov) begin
      if (req >= 0 && oks[req]) want = req;
    end else if (algn) begin
      if (req >= 0 && oks[req]) want = req;
      else if (oks[mdir])       want = mdir;
    end else begin
      want = (req >= 0 && req == (mdir ^ 1)) ? req : mdir;
    end
    if (want < 0) begin
      mdir = -1; mmov = 0;
      return;
    end
    tx = mx + dxs[want];
    ty = my + dys[want];
    stop = 0;
    if (tx < 0 || tx > 624) begin
`ifdef GHOST_TUNNEL_EN
      tx = (tx < 0) ? 624 : 0;
`else
      stop = 1;
`endif
    end
    if (ty < 0 || ty > 479) stop = 1;
    if (stop) begin
      mdir = -1; mmov = 0;
    end else begin
      mx = tx; my = ty; mdir = want; mmov = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x"},   16'(GhostX),   16'(mx));
    chk({tag, ".y"},   16'(GhostY),   16'(my));
    chk({tag, ".dir"}, 16'(GhostDir), 16'(onehot_of(mdir)));
    chk({tag, ".mov"}, 16'(Moving),   16'(mmov));
  endtask

  task automatic set_in(input logic [3:0] mov, input logic [3:0] oks);
    Movement = mov;
    {down_ok, up_ok, right_ok, left_ok} = oks;
  endtask

  // One frame: inputs held through the tick, then scrambled afterwards so
  // that sampling outside the tick cycle would show up on the next frame.
  task automatic frame(input string tag, input logic [3:0] mov, input logic [3:0] oks);
    set_in(mov, oks);
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (2) @(posedge Clk); #1 frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    model_tick(mov, oks);
    @(negedge Clk);
    check_all(tag);
    set_in(4'($urandom), 4'($urandom));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
  endtask

  logic [3:0] rm, ro;

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; Over = 1'b0;
    set_in(4'd0, 4'd0);
    model_reset();
    repeat (2) @(posedge Clk);

    // 1: reset values, idle frame with no request
    do_reset();
    chk("t1.x", 16'(GhostX), 16'd320);
    chk("t1.dir", 16'(GhostDir), 16'd0);
    frame("t1.idle", 4'b0000, 4'b1111);

    // 2: first step up, with tick latency checked cycle by cycle
    set_in(4'b0100, 4'b0100);
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("t2.before_tick.y", 16'(GhostY), 16'd240);
    @(posedge Clk); #1 frame_clk = 1'b0;
    model_tick(4'b0100, 4'b0100);
    @(negedge Clk);
    check_all("t2");
    chk("t2.y", 16'(GhostY), 16'd238);
    chk("t2.dir", 16'(GhostDir), 16'b0100);
    repeat (3) @(posedge Clk);

    // 3: left request mid-tile is deferred until aligned at Y=224
    for (int i = 0; i < 7; i++) frame("t3.up", 4'b0001, 4'b0001);
    chk("t3.y224", 16'(GhostY), 16'd224);
    frame("t3.turn", 4'b0001, 4'b0001);
    chk("t3.x318", 16'(GhostX), 16'd318);
    chk("t3.dirleft", 16'(GhostDir), 16'b0001);

    // 4: mid-tile reversal without any wall check (reset aborts current move)
    do_reset();
    frame("t4.up", 4'b0100, 4'b0100);
    frame("t4.rev", 4'b1000, 4'b0000);
    chk("t4.y240", 16'(GhostY), 16'd240);
    chk("t4.dirdown", 16'(GhostDir), 16'b1000);

    // 5: wall stop when aligned, then freeze while moving
    do_reset();
    for (int i = 0; i < 8; i++) frame("t5.right", 4'b0010, 4'b0010);
    frame("t5.wall", 4'b0100, 4'b0000);
    chk("t5.x336", 16'(GhostX), 16'd336);
    chk("t5.stopped", 16'(Moving), 16'd0);
    frame("t5.go", 4'b0010, 4'b0010);
    @(posedge Clk); #1 Over = 1'b1;
    mfrz = 1; mmov = 0;
    for (int i = 0; i < 5; i++) frame("t5.frozen", 4'b0010, 4'b0010);
    chk("t5.frz.x", 16'(GhostX), 16'd338);
    @(posedge Clk); #1 Over = 1'b0;
    mfrz = 0; mdir = -1; mmov = 0;
    @(posedge Clk); @(negedge Clk);
    check_all("t5.release");

    // 6: left edge
    do_reset();
    for (int i = 0; i < 160; i++) frame("t6.left", 4'b0001, 4'b0001);
    chk("t6.x0", 16'(GhostX), 16'd0);
    frame("t6.edge", 4'b0001, 4'b0001);
`ifdef GHOST_TUNNEL_EN
    chk("t6.wrap", 16'(GhostX), 16'd624);
    chk("t6.mov", 16'(Moving), 16'd1);
`else
    chk("t6.clamp", 16'(GhostX), 16'd0);
    chk("t6.mov", 16'(Moving), 16'd0);
`endif

    // 7: randomized requests, wall flags and occasional freezes
    do_reset();
    for (int i = 0; i < 150; i++) begin
      rm = $urandom_range(0, 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      ro = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge Clk); #1 Over = 1'b1;
        mfrz = 1; mmov = 0;
        frame("rnd.frozen", rm, ro);
        @(posedge Clk); #1 Over = 1'b0;
        mfrz = 0; mdir = -1; mmov = 0;
        @(posedge Clk); @(negedge Clk);
        check_all("rnd.release");
      end else begin
        frame("rnd", rm, ro);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
